// File: rtl/id_hazard_ctrl.sv
// Decode-stage sequencer: IF/ID register, ID/EX tracker, load-use stall, branch flush, mem freeze.
// Optional performance counters enabled by defining HAZ_PERF_CNT_EN (otherwise tied to 0).
module id_hazard_ctrl #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic [4:0]      dec_rs1_addr,
    input  logic [4:0]      dec_rs2_addr,
    input  logic [6:0]      dec_opcode,
    input  logic            dec_r_type,
    input  logic            dec_i_type,
    input  logic            dec_s_type,
    input  logic            dec_b_type,
    input  logic            dec_u_type,
    input  logic            dec_j_type,
    input  logic            ex_branch_taken,
    input  logic            mem_busy,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            pc_en,
    output logic            ex_issue,
    output logic            stall_o,
    output logic            flush_o,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt,
    output logic [31:0]     freeze_cnt
);
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

    state_t            state_q, state_d;
    logic              id_valid_q, id_valid_d;
    logic [31:0]       id_instr_q, id_instr_d;
    logic [XLEN-1:0]   id_pc_q, id_pc_d;
    logic              ex_valid_q, ex_valid_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic              ex_load_q, ex_load_d;
    logic              rs1_used, rs2_used, hazard;
    logic              unused_type_flags;

    // U/J formats read no registers; their flags only matter by absence from the use terms.
    assign unused_type_flags = dec_u_type | dec_j_type;

    always_comb begin
        rs1_used = dec_r_type | dec_i_type | dec_s_type | dec_b_type;
        rs2_used = dec_r_type | dec_s_type | dec_b_type;
        hazard   = id_valid_q & ex_valid_q & ex_load_q & (ex_rd_q != 5'd0) &
                   ((rs1_used & (dec_rs1_addr == ex_rd_q)) |
                    (rs2_used & (dec_rs2_addr == ex_rd_q)));

        state_d    = state_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        ex_valid_d = ex_valid_q;
        ex_rd_d    = ex_rd_q;
        ex_load_d  = ex_load_q;
        pc_en      = 1'b0;
        ex_issue   = 1'b0;
        stall_o    = 1'b0;
        flush_o    = 1'b0;

        if (rst_n) begin
            stall_o = (state_q == LU_STALL);
            flush_o = (state_q == FLUSH);
            if (mem_busy) begin
                // whole pipeline frozen: hold everything
            end else if (ex_branch_taken) begin
                pc_en      = 1'b1;
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
                ex_valid_d = 1'b0;
                state_d    = FLUSH;
            end else if (hazard) begin
                ex_valid_d = 1'b0;
                state_d    = LU_STALL;
            end else begin
                pc_en      = 1'b1;
                ex_issue   = id_valid_q;
                id_valid_d = if_valid;
                id_instr_d = if_valid ? if_instr : NOP_INSTR;
                id_pc_d    = if_pc;
                ex_valid_d = id_valid_q;
                if (id_valid_q) begin
                    ex_rd_d   = id_instr_q[11:7];
                    ex_load_d = (dec_opcode == OP_LOAD);
                end
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= '0;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= 5'd0;
            ex_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
            ex_load_q  <= ex_load_d;
        end
    end

    assign id_valid = id_valid_q;
    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] freeze_cnt_q, freeze_cnt_d;

    // Counters saturate rather than wrap so long runs never report a small bogus value.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        if (mem_busy) begin
            if (freeze_cnt_q != 32'hFFFF_FFFF) freeze_cnt_d = freeze_cnt_q + 32'd1;
        end else if (ex_branch_taken) begin
            if (flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
        end else if (hazard) begin
            if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q  <= 32'd0;
            flush_cnt_q  <= 32'd0;
            freeze_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
`else
    assign stall_cnt  = 32'd0;
    assign flush_cnt  = 32'd0;
    assign freeze_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed cycle table for the hazard/flush/freeze/reset cases,
// then randomized traffic compared against a pipeline-slot reference model.
module tb_id_hazard_ctrl;
`ifdef HAZ_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, if_valid, ex_branch_taken, mem_busy;
    logic [31:0] if_instr, if_pc;
    logic [4:0]  dec_rs1_addr, dec_rs2_addr;
    logic [6:0]  dec_opcode;
    logic        dec_r_type, dec_i_type, dec_s_type, dec_b_type, dec_u_type, dec_j_type;
    logic        id_valid, pc_en, ex_issue, stall_o, flush_o;
    logic [31:0] id_instr, id_pc, stall_cnt, flush_cnt, freeze_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr), .dec_opcode(dec_opcode),
        .dec_r_type(dec_r_type), .dec_i_type(dec_i_type), .dec_s_type(dec_s_type),
        .dec_b_type(dec_b_type), .dec_u_type(dec_u_type), .dec_j_type(dec_j_type),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .pc_en(pc_en),
        .ex_issue(ex_issue), .stall_o(stall_o), .flush_o(flush_o),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    // Stand-in for the decoder: fields and format flags of whatever sits in IF/ID.
    always_comb begin
        dec_opcode   = id_instr[6:0];
        dec_rs1_addr = id_instr[19:15];
        dec_rs2_addr = id_instr[24:20];
        dec_r_type   = (dec_opcode == 7'h33);
        dec_i_type   = (dec_opcode == 7'h13) || (dec_opcode == 7'h03) ||
                       (dec_opcode == 7'h67) || (dec_opcode == 7'h73);
        dec_s_type   = (dec_opcode == 7'h23);
        dec_b_type   = (dec_opcode == 7'h63);
        dec_u_type   = (dec_opcode == 7'h37) || (dec_opcode == 7'h17);
        dec_j_type   = (dec_opcode == 7'h6f);
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input logic [31:0] v);
        return CNT_EN ? v : 32'd0;
    endfunction

    typedef struct {
        logic        rst, iv;
        logic [31:0] ins;
        logic        br, busy;
        logic        pc_en, iss, stl, fls, idv;
        logic [31:0] idi, sc, fc, zc;
    } vec_t;

    function automatic vec_t mk(input logic rst, iv, input logic [31:0] ins, input logic br, busy,
                                input logic pe, is, st, fl, iv2, input logic [31:0] idi,
                                input logic [31:0] sc, fc, zc);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ins = ins; v.br = br; v.busy = busy;
        v.pc_en = pe; v.iss = is; v.stl = st; v.fls = fl; v.idv = iv2;
        v.idi = idi; v.sc = sc; v.fc = fc; v.zc = zc;
        return v;
    endfunction

    // Reference model state: contents of the ID slot and EX slot, plus whether the
    // previous active cycle was a load-use bubble or a branch redirect.
    logic        m_idv, m_exv, m_exld, m_after_haz, m_after_br;
    logic [31:0] m_idi, m_idpc, m_sc, m_fc, m_zc;
    logic [4:0]  m_exrd;

    function automatic bit reads_rs1(input logic [31:0] ins);
        return ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63};
    endfunction
    function automatic bit reads_rs2(input logic [31:0] ins);
        return ins[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, rs1, rs2;
        rd  = 5'($urandom_range(0, 3));
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 6))
            0: return {12'h004, rs1, 3'b010, rd, 7'h03};
            1: return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
            2: return {12'h001, rs1, 3'b000, rd, 7'h13};
            3: return {7'h00, rs2, rs1, 3'b010, 5'd0, 7'h23};
            4: return {7'h00, rs2, rs1, 3'b000, 5'd0, 7'h63};
            5: return {20'h12345, rd, 7'h37};
            default: return {20'h00000, rd, 7'h6f};
        endcase
    endfunction

    vec_t vq[$];

    initial begin
        localparam logic [31:0] LW5  = 32'h0000A283;  // lw   x5,0(x1)
        localparam logic [31:0] ADD  = 32'h00228333;  // add  x6,x5,x2
        localparam logic [31:0] LW0  = 32'h0000A003;  // lw   x0,0(x1)
        localparam logic [31:0] ADD0 = 32'h00200333;  // add  x6,x0,x2
        localparam logic [31:0] ADDI = 32'h00100293;  // addi x5,x0,1
        localparam logic [31:0] LUI  = 32'h123452B7;  // lui  x5,0x12345
        localparam logic [31:0] SW   = 32'h0050A023;  // sw   x5,0(x1)
        vec_t v;
        logic rst, iv, br, busy, hz, e_pc, e_iss;
        logic [31:0] ins, pc;

        rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
        ex_branch_taken = 1'b0; mem_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_en", 0, 32'(pc_en), 0);
        chk("rst_ex_issue", 0, 32'(ex_issue), 0);
        chk("rst_id_valid", 0, 32'(id_valid), 0);
        chk("rst_id_instr", 0, id_instr, NOP);
        chk("rst_id_pc", 0, id_pc, 0);
        chk("rst_stall_cnt", 0, stall_cnt, 0);

        //                rst iv ins   br bsy pe is st fl idv idi   sc fc zc
        vq.push_back(mk(1, 1, LW5,  0, 0,  1, 0, 0, 0, 0, NOP,  0, 0, 0));  // 0
        vq.push_back(mk(1, 1, ADD,  0, 0,  1, 1, 0, 0, 1, LW5,  0, 0, 0));
        vq.push_back(mk(1, 1, NOP,  0, 0,  0, 0, 0, 0, 1, ADD,  0, 0, 0));  // load-use bubble
        vq.push_back(mk(1, 1, NOP,  0, 0,  1, 1, 1, 0, 1, ADD,  1, 0, 0));
        vq.push_back(mk(1, 1, LW0,  0, 0,  1, 1, 0, 0, 1, NOP,  1, 0, 0));
        vq.push_back(mk(1, 1, ADD0, 0, 0,  1, 1, 0, 0, 1, LW0,  1, 0, 0));  // 5
        vq.push_back(mk(1, 1, ADDI, 0, 0,  1, 1, 0, 0, 1, ADD0, 1, 0, 0));  // rd=x0: no stall
        vq.push_back(mk(1, 1, ADD,  0, 0,  1, 1, 0, 0, 1, ADDI, 1, 0, 0));
        vq.push_back(mk(1, 1, LW5,  0, 0,  1, 1, 0, 0, 1, ADD,  1, 0, 0));  // non-load producer
        vq.push_back(mk(1, 1, LUI,  0, 0,  1, 1, 0, 0, 1, LW5,  1, 0, 0));
        vq.push_back(mk(1, 1, LW5,  0, 0,  1, 1, 0, 0, 1, LUI,  1, 0, 0));  // 10: lui reads nothing
        vq.push_back(mk(1, 1, SW,   0, 0,  1, 1, 0, 0, 1, LW5,  1, 0, 0));
        vq.push_back(mk(1, 1, NOP,  0, 0,  0, 0, 0, 0, 1, SW,   1, 0, 0));  // rs2 match
        vq.push_back(mk(1, 1, NOP,  0, 0,  1, 1, 1, 0, 1, SW,   2, 0, 0));
        vq.push_back(mk(1, 1, ADD,  0, 0,  1, 1, 0, 0, 1, NOP,  2, 0, 0));
        vq.push_back(mk(1, 1, ADDI, 1, 0,  1, 0, 0, 0, 1, ADD,  2, 0, 0));  // 15: branch
        vq.push_back(mk(1, 1, LUI,  0, 0,  1, 0, 0, 1, 0, NOP,  2, 1, 0));
        vq.push_back(mk(1, 1, LW5,  0, 0,  1, 1, 0, 0, 1, LUI,  2, 1, 0));
        vq.push_back(mk(1, 1, ADD,  0, 0,  1, 1, 0, 0, 1, LW5,  2, 1, 0));
        vq.push_back(mk(1, 1, NOP,  0, 1,  0, 0, 0, 0, 1, ADD,  2, 1, 0));  // freeze x3
        vq.push_back(mk(1, 1, NOP,  0, 1,  0, 0, 0, 0, 1, ADD,  2, 1, 1));  // 20
        vq.push_back(mk(1, 1, NOP,  0, 1,  0, 0, 0, 0, 1, ADD,  2, 1, 2));
        vq.push_back(mk(1, 1, NOP,  0, 0,  0, 0, 0, 0, 1, ADD,  2, 1, 3));
        vq.push_back(mk(1, 1, NOP,  0, 0,  1, 1, 1, 0, 1, ADD,  3, 1, 3));
        vq.push_back(mk(1, 1, LW5,  0, 0,  1, 1, 0, 0, 1, NOP,  3, 1, 3));
        vq.push_back(mk(1, 1, ADD,  0, 0,  1, 1, 0, 0, 1, LW5,  3, 1, 3));  // 25
        vq.push_back(mk(1, 1, NOP,  0, 0,  0, 0, 0, 0, 1, ADD,  3, 1, 3));
        vq.push_back(mk(0, 1, NOP,  0, 0,  0, 0, 0, 0, 1, ADD,  4, 1, 3));  // reset in LU_STALL
        vq.push_back(mk(1, 0, NOP,  0, 0,  1, 0, 0, 0, 0, NOP,  0, 0, 0));
        vq.push_back(mk(1, 0, NOP,  0, 0,  1, 0, 0, 0, 0, NOP,  0, 0, 0));

        foreach (vq[k]) begin
            v = vq[k];
            rst_n = v.rst; if_valid = v.iv; if_instr = v.ins; if_pc = 32'h100 + 32'(k) * 4;
            ex_branch_taken = v.br; mem_busy = v.busy;
            #1;
            chk("pc_en", k, 32'(pc_en), 32'(v.pc_en));
            chk("ex_issue", k, 32'(ex_issue), 32'(v.iss));
            chk("stall_o", k, 32'(stall_o), 32'(v.stl));
            chk("flush_o", k, 32'(flush_o), 32'(v.fls));
            chk("id_valid", k, 32'(id_valid), 32'(v.idv));
            chk("id_instr", k, id_instr, v.idi);
            chk("stall_cnt", k, stall_cnt, cexp(v.sc));
            chk("flush_cnt", k, flush_cnt, cexp(v.fc));
            chk("freeze_cnt", k, freeze_cnt, cexp(v.zc));
            @(posedge clk);
            #1;
        end

        m_idv = 0; m_idi = NOP; m_idpc = 0; m_exv = 0; m_exrd = 0; m_exld = 0;
        m_after_haz = 0; m_after_br = 0; m_sc = 0; m_fc = 0; m_zc = 0;
        for (int i = 0; i < 3000; i++) begin
            rst  = (i == 0) || ($urandom_range(0, 99) < 2);
            iv   = ($urandom_range(0, 3) != 0);
            ins  = rand_instr();
            pc   = $urandom & 32'hFFFF_FFFC;
            br   = !m_after_br && ($urandom_range(0, 99) < 10);
            busy = ($urandom_range(0, 99) < 15);
            rst_n = rst; if_valid = iv; if_instr = ins; if_pc = pc;
            ex_branch_taken = br; mem_busy = busy;
            #1;
            if (flush_o && ex_branch_taken) begin
                errors++;
                $display("FAIL branch_in_flush @%0d: got 1 expected 0", i);
            end
            if (i > 0) begin
                chk("r_id_valid", i, 32'(id_valid), 32'(m_idv));
                chk("r_id_instr", i, id_instr, m_idi);
                if (m_idv) chk("r_id_pc", i, id_pc, m_idpc);
                chk("r_stall_o", i, 32'(stall_o), 32'(rst & m_after_haz));
                chk("r_flush_o", i, 32'(flush_o), 32'(rst & m_after_br));
                chk("r_stall_cnt", i, stall_cnt, cexp(m_sc));
                chk("r_flush_cnt", i, flush_cnt, cexp(m_fc));
                chk("r_freeze_cnt", i, freeze_cnt, cexp(m_zc));
            end
            hz = m_idv && m_exv && m_exld && (m_exrd != 0) &&
                 ((reads_rs1(m_idi) && m_idi[19:15] == m_exrd) ||
                  (reads_rs2(m_idi) && m_idi[24:20] == m_exrd));
            e_pc = 0; e_iss = 0;
            if (!rst) begin
                m_idv = 0; m_idi = NOP; m_idpc = 0; m_exv = 0; m_exrd = 0; m_exld = 0;
                m_after_haz = 0; m_after_br = 0; m_sc = 0; m_fc = 0; m_zc = 0;
            end else if (busy) begin
                if (m_zc != 32'hFFFF_FFFF) m_zc++;
            end else if (br) begin
                e_pc = 1;
                m_idv = 0; m_idi = NOP; m_exv = 0;
                m_after_br = 1; m_after_haz = 0;
                if (m_fc != 32'hFFFF_FFFF) m_fc++;
            end else if (hz) begin
                m_exv = 0;
                m_after_haz = 1; m_after_br = 0;
                if (m_sc != 32'hFFFF_FFFF) m_sc++;
            end else begin
                e_pc = 1; e_iss = m_idv;
                m_exv = m_idv;
                if (m_idv) begin
                    m_exrd = m_idi[11:7];
                    m_exld = (m_idi[6:0] == 7'h03);
                end
                m_idv = iv; m_idi = iv ? ins : NOP; m_idpc = pc;
                m_after_haz = 0; m_after_br = 0;
            end
            chk("r_pc_en", i, 32'(pc_en), 32'(e_pc));
            chk("r_ex_issue", i, 32'(ex_issue), 32'(e_iss));
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
